// File: rtl/simple_cpu_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : simple_cpu_prog_loader
//  Description : Host-side writer for the 4-bit CPU instruction memory.
//                Streams instruction words in over valid/ready, writes them
//                from address 0 upward, reads them back through the fetch
//                address path, compares an XOR checksum and releases the CPU
//                from reset only after a verified load.
//  Revision    : 1.0 - initial release
// ============================================================================
module simple_cpu_prog_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_FLUSH  = 3'd2,
        S_VERIFY = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [ADDR_W:0] C_DEPTH = DEPTH[ADDR_W:0];

    state_t              r_state;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W:0]     r_idx;
    logic                r_in_ready;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_done;
    logic                r_err;
    logic                r_loaded;
    logic [DATA_W-1:0]   r_checksum;
    logic [DATA_W-1:0]   r_vsum;
    logic                r_rd_valid;

    logic [ADDR_W:0]     w_len_clamped;
    logic [ADDR_W:0]     w_len_m1;
    logic                w_hs;
    logic [DATA_W-1:0]   w_final_sum;

    // Requests longer than the memory are clamped so the address never wraps
    assign w_len_clamped = (load_len > C_DEPTH) ? C_DEPTH : load_len;
    assign w_len_m1      = r_len - 1'b1;
    assign w_hs          = in_valid & r_in_ready;
    // The read data present in CHECK belongs to the last verify address
    assign w_final_sum   = r_vsum ^ mem_rdata;

    assign in_ready  = r_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign done      = r_done;
    assign err       = r_err;
    assign checksum  = r_checksum;
    assign busy      = (r_state != S_IDLE);
    // Derived only from registers, so the CPU reset cannot glitch
    assign cpu_reset = ~(r_loaded & (r_state == S_IDLE));

    // Load / flush / verify / check sequencer with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_loaded    <= 1'b0;
            r_checksum  <= '0;
            r_vsum      <= '0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_err      <= 1'b0;
                        r_checksum <= '0;
                        if (load_len == '0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_len      <= w_len_clamped;
                            r_idx      <= '0;
                            r_loaded   <= 1'b0;
                            r_in_ready <= 1'b1;
                            r_state    <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_hs) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_idx[ADDR_W-1:0];
                        r_mem_wdata <= in_data;
                        r_checksum  <= r_checksum ^ in_data;
                        r_idx       <= r_idx + 1'b1;
                        if (r_idx == w_len_m1) begin
                            r_in_ready <= 1'b0;
                            r_state    <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    // Last write lands this cycle; readback starts at 0 next
                    r_mem_addr <= '0;
                    r_vsum     <= '0;
                    r_rd_valid <= 1'b0;
                    r_state    <= S_VERIFY;
                end
                S_VERIFY: begin
                    // Read data lags the address by one cycle
                    if (r_rd_valid) begin
                        r_vsum <= r_vsum ^ mem_rdata;
                    end
                    r_rd_valid <= 1'b1;
                    if ({1'b0, r_mem_addr} == w_len_m1) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_mem_addr <= r_mem_addr + 1'b1;
                    end
                end
                S_CHECK: begin
                    r_vsum <= w_final_sum;
                    if (w_final_sum != r_checksum) begin
                        r_err <= 1'b1;
                    end else begin
                        r_loaded <= 1'b1;
                    end
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_simple_cpu_prog_loader.sv
`timescale 1ns/1ps
`default_nettype none
module tb_simple_cpu_prog_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [4:0] load_len = '0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       cpu_reset;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] checksum;

    simple_cpu_prog_loader #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .load_len  (load_len),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory model with optional readback corruption
    logic [7:0] mem [16];
    logic       corrupt_en = 1'b0;
    logic [3:0] corrupt_addr = '0;
    logic [7:0] corrupt_val = '0;
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= (corrupt_en && mem_addr == corrupt_addr) ? corrupt_val : mem[mem_addr];
    end

    typedef struct packed {
        logic [3:0]  addr;
        logic [7:0]  data;
        logic [31:0] cyc;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    int         n_vec = 0;
    int         n_miss = 0;
    logic [7:0] words [16];
    logic [7:0] exp_sum = '0;
    logic [3:0] wr_idx = '0;

    // Write monitor: every mem_we pulse must match the next expected write
    always @(posedge clk) begin
        #1;
        if (mem_we === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL wr_unexpected: got addr=%0h data=%0h cyc=%0d, required no write", mem_addr, mem_wdata, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data || cyc != int'(mon_e.cyc)) begin
                    n_miss++;
                    $display("FAIL wr_match: got addr=%0h data=%0h cyc=%0d, required addr=%0h data=%0h cyc=%0d",
                             mem_addr, mem_wdata, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
                end
            end
        end
    end

    task automatic begin_load(input logic [4:0] len);
        exp_sum  = '0;
        wr_idx   = '0;
        start    = 1'b1;
        load_len = len;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if ({in_ready, busy, err, checksum} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
            n_miss++;
            $display("FAIL start_accept: got ready=%b busy=%b err=%b sum=%h, required 1 1 0 00",
                     in_ready, busy, err, checksum);
        end
    endtask

    task automatic drive_load(input int n, input int gap, input int glitch_at, output int hs_cyc);
        int i = 0;
        int g = 0;
        int budget = 0;
        hs_cyc = 0;
        while (i < n && budget < 400) begin
            if (g > 0) begin
                in_valid = 1'b0;
                g--;
            end else begin
                in_valid = 1'b1;
                in_data  = words[i];
            end
            start = (i == glitch_at);
            if (i == glitch_at) load_len = 5'd9;
            if (in_valid && in_ready) begin
                exp_q.push_back('{addr: wr_idx, data: words[i], cyc: 32'(cyc + 1)});
                exp_sum = exp_sum ^ words[i];
                wr_idx  = wr_idx + 4'd1;
                hs_cyc  = cyc + 1;
                i++;
                g = gap;
            end
            @(negedge clk);
            budget++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (i < n) begin
            n_vec++;
            n_miss++;
            $display("FAIL load_timeout: got %0d words accepted, required %0d", i, n);
        end
    endtask

    task automatic finish_load(input int len, input logic exp_err, input int hs_cyc);
        int seen = 0;
        int budget = 0;
        logic [3:0] ea;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL ready_drop: got in_ready=%b, required 0", in_ready);
        end
        while (seen == 0 && budget < len + 10) begin
            if (cyc >= hs_cyc + 1 && cyc <= hs_cyc + len) begin
                ea = 4'(cyc - hs_cyc - 1);
                n_vec++;
                if (mem_addr !== ea || mem_we !== 1'b0) begin
                    n_miss++;
                    $display("FAIL rb_addr: got addr=%0h we=%b, required addr=%0h we=0", mem_addr, mem_we, ea);
                end
            end
            if (done === 1'b1) seen = 1;
            else begin
                @(negedge clk);
                budget++;
            end
        end
        n_vec++;
        if (seen == 0) begin
            n_miss++;
            $display("FAIL done_timeout: got no done pulse, required one");
        end else begin
            if (cyc != hs_cyc + len + 2) begin
                n_miss++;
                $display("FAIL done_latency: got cycle %0d, required %0d", cyc, hs_cyc + len + 2);
            end
            n_vec++;
            if ({err, checksum, cpu_reset, busy} !== {exp_err, exp_sum, 1'b1, 1'b1}) begin
                n_miss++;
                $display("FAIL done_state: got err=%b sum=%h cpu_rst=%b busy=%b, required %b %h 1 1",
                         err, checksum, cpu_reset, busy, exp_err, exp_sum);
            end
        end
        @(negedge clk);
        n_vec++;
        if ({done, busy, cpu_reset} !== {1'b0, 1'b0, exp_err} || exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL after_done: got done=%b busy=%b cpu_rst=%b pending=%0d, required 0 0 %b 0",
                     done, busy, cpu_reset, exp_q.size(), exp_err);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_vec++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, err, checksum}
            !== {1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_miss++;
            $display("FAIL reset_values: got rdy=%b we=%b a=%h d=%h cr=%b bs=%b dn=%b er=%b cs=%h, required 0 0 0 00 1 0 0 0 00",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, err, checksum);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_basic_words;
        words[0] = 8'h12;
        words[1] = 8'h34;
        words[2] = 8'h5F;
    endtask

    task automatic test_basic;
        int hs;
        set_basic_words();
        begin_load(5'd3);
        drive_load(3, 0, -1, hs);
        n_vec++;
        if (checksum !== 8'h79) begin
            n_miss++;
            $display("FAIL basic_checksum: got %h, required 79", checksum);
        end
        finish_load(3, 1'b0, hs);
    endtask

    task automatic test_gaps;
        int hs;
        set_basic_words();
        begin_load(5'd3);
        drive_load(3, 2, -1, hs);
        n_vec++;
        if (checksum !== 8'h79) begin
            n_miss++;
            $display("FAIL gap_checksum: got %h, required 79", checksum);
        end
        finish_load(3, 1'b0, hs);
    endtask

    task automatic test_corrupt;
        int hs;
        set_basic_words();
        corrupt_en   = 1'b1;
        corrupt_addr = 4'd1;
        corrupt_val  = 8'h35;
        begin_load(5'd3);
        drive_load(3, 0, -1, hs);
        finish_load(3, 1'b1, hs);
        corrupt_en = 1'b0;
    endtask

    task automatic test_full;
        int hs;
        for (int k = 0; k < 16; k++) words[k] = 8'(k);
        begin_load(5'd16);
        drive_load(16, 0, -1, hs);
        finish_load(16, 1'b0, hs);
        // Oversized request is clamped to the memory depth
        for (int k = 0; k < 16; k++) words[k] = 8'(8'hA0 + k);
        begin_load(5'd31);
        drive_load(16, 0, -1, hs);
        finish_load(16, 1'b0, hs);
    endtask

    task automatic test_zero_and_ignore;
        int hs;
        int c0;
        int seen = 0;
        c0 = cyc;
        start    = 1'b1;
        load_len = 5'd0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4 && seen == 0; k++) begin
            if (done === 1'b1) seen = 1;
            else @(negedge clk);
        end
        n_vec++;
        if (seen == 0 || cyc - c0 > 2 || err !== 1'b0) begin
            n_miss++;
            $display("FAIL zero_len: got done_seen=%0d after %0d cycles err=%b, required done within 2 err=0",
                     seen, cyc - c0, err);
        end
        @(negedge clk);
        n_vec++;
        if ({done, busy} !== 2'b00) begin
            n_miss++;
            $display("FAIL zero_len_end: got done=%b busy=%b, required 0 0", done, busy);
        end
        words[0] = 8'hA5;
        words[1] = 8'h3C;
        begin_load(5'd2);
        drive_load(2, 1, 1, hs);
        finish_load(2, 1'b0, hs);
    endtask

    task automatic test_midreset;
        int hs;
        set_basic_words();
        begin_load(5'd3);
        in_valid = 1'b1;
        in_data  = words[0];
        if (in_ready === 1'b1) exp_q.push_back('{addr: 4'd0, data: words[0], cyc: 32'(cyc + 1)});
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        n_vec++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, err, checksum}
            !== {1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00} || exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL midreset: got rdy=%b we=%b a=%h d=%h cr=%b bs=%b dn=%b er=%b cs=%h pend=%0d, required 0 0 0 00 1 0 0 0 00 0",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, err, checksum, exp_q.size());
        end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        begin_load(5'd3);
        drive_load(3, 0, -1, hs);
        finish_load(3, 1'b0, hs);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_corrupt();
        test_full();
        test_zero_and_ignore();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/simple_cpu_prog_loader.md
Name: simple_cpu_prog_loader

Overview:
Host-side writer for the 4-bit CPU's instruction memory. It accepts a stream of 8-bit instruction words (opcode[7:4], operand[3:0]) over a valid/ready handshake and writes them sequentially from address 0. It then reads the memory back through the same address path that the CPU fetch uses, and checks the result against an XOR checksum. It holds the CPU in reset until a load has been verified.

Parameters:
ADDR_W, 4, memory address width (matches CPU memory_address)
DATA_W, 8, instruction word width
DEPTH, 16, number of memory words (2**ADDR_W)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse that begins a load; ignored unless idle
load_len  input  ADDR_W+1  number of words to load (0..DEPTH), sampled when start is accepted
in_data  input  DATA_W  instruction word
in_valid  input  1  in_data is valid
in_ready  output  1  loader accepts a word this cycle
mem_we  output  1  memory write strobe
mem_addr  output  ADDR_W  memory address (write and readback)
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid 1 cycle after mem_addr
cpu_reset  output  1  reset to the CPU; high until a verified load completes
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse at the end of a load
err  output  1  verify mismatch; sticky until the next accepted start
checksum  output  DATA_W  XOR of all words accepted in the current load

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, busy=0, done=0, err=0, checksum=0, loaded flag=0, state=IDLE.
- Reset mid-operation aborts immediately and restores all reset values. The CPU stays in reset.
- States: IDLE, LOAD, FLUSH, VERIFY, CHECK, DONE.
- IDLE:
  - start=1 with load_len>0: latch len, clear checksum, clear err, clear loaded, go to LOAD.
  - start=1 with load_len=0: go to DONE with no writes and err=0.
  - start=1 with load_len>DEPTH: clamp to DEPTH.
- LOAD:
  - in_ready=1.
  - A handshake (in_valid&in_ready) at cycle t gives mem_we=1, mem_addr=idx and mem_wdata=in_data at cycle t+1, for exactly one cycle. checksum^=in_data. idx increments.
  - in_valid=0 produces no write and no state change; gaps of any length are allowed.
  - When the handshake for word len-1 occurs, in_ready drops the next cycle and the state goes to FLUSH.
- FLUSH: one cycle; the last write completes. verify checksum=0, rd_idx=0.
- VERIFY:
  - mem_we=0. mem_addr=rd_idx, incrementing by 1 per cycle through len-1.
  - mem_rdata is XORed into the verify checksum one cycle after each address.
  - After the address len-1 cycle, go to CHECK.
- CHECK: captures the final mem_rdata, then compares the verify checksum to checksum. On mismatch err=1; otherwise loaded=1. Go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- cpu_reset = ~(loaded & state==IDLE). It is combinationally derived from registered state, so it is glitch-free.
- start while busy is ignored, with no effect on len or counters.
- Address counter never wraps: a full load of len=16 writes addresses 0..15 only. The idx counter is ADDR_W+1 bits wide.
- Latency:
  - start to first in_ready: 1 cycle.
  - Last handshake to done: 1 (FLUSH) + len (VERIFY) + 1 (CHECK) + 1 cycles.

Test Plan:
1. len=3, words 0x12,0x34,0x5F, in_valid continuous, ideal memory model -> writes (0,0x12),(1,0x34),(2,0x5F) on consecutive cycles; checksum=0x79; readback addrs 0,1,2; done pulse; err=0; cpu_reset falls the cycle after done.
2. Same load with in_valid deasserted for 2 cycles between words -> identical writes, no extra mem_we pulses, checksum=0x79.
3. Memory model corrupts addr 1 to 0x35 on readback -> err=1, done pulses, cpu_reset stays 1; next start clears err.
4. len=16, words 0x00..0x0F -> last write at addr 15, no write to addr 0 after it, checksum=0x00, err=0.
5. len=0 -> done pulses 2 cycles after start, no mem_we; start asserted during LOAD of a len=2 load -> ignored, exactly 2 writes.
6. reset asserted after 1 of 3 words -> outputs return to reset values immediately, cpu_reset=1, busy=0; a fresh load then succeeds.
